// File: rtl/wb_byte_unpacker.sv
// Write-back serialiser: takes wide words from the BRAM read side and writes
// them to an 8-bit external memory as consecutive bytes, one byte per cycle.
module wb_byte_unpacker #(
  parameter int DATA_WIDTH_W = 32,
  parameter int DATA_WIDTH_R = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    num_words,
  input  logic                    msb_first,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH_W-1:0] in_data,
  output logic                    in_ready,
  output logic                    e_mem_we,
  output logic [ADDR_WIDTH-1:0]   e_mem_addr,
  output logic [DATA_WIDTH_R-1:0] e_mem_wdata,
  output logic                    busy,
  output logic                    complete
);

  localparam int N  = DATA_WIDTH_W / DATA_WIDTH_R;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [CNT_WIDTH-1:0]    num_q, num_d;
  logic [CNT_WIDTH-1:0]    acc_cnt_q, acc_cnt_d;
  logic                    msb_q, msb_d;
  logic [DATA_WIDTH_W-1:0] buf_q, buf_d;
  logic                    full_q, full_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH_R-1:0] wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    complete_q, complete_d;

  logic [DATA_WIDTH_R-1:0] in_lane  [N];
  logic [DATA_WIDTH_R-1:0] buf_lane [N];
  logic                    accept;
  logic [LW-1:0]           lane_nxt;

  // Lane k in transmission order, for both the incoming word and the buffer.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign in_lane[gi]  = msb_q ? in_data[DATA_WIDTH_W-1-gi*DATA_WIDTH_R -: DATA_WIDTH_R]
                                  : in_data[gi*DATA_WIDTH_R +: DATA_WIDTH_R];
      assign buf_lane[gi] = msb_q ? buf_q[DATA_WIDTH_W-1-gi*DATA_WIDTH_R -: DATA_WIDTH_R]
                                  : buf_q[gi*DATA_WIDTH_R +: DATA_WIDTH_R];
    end
  endgenerate

  // Ready while the buffer is free or in its final lane, so words stream gaplessly.
  assign in_ready = (state_q == RUN) && (acc_cnt_q < num_q) &&
                    (!full_q || (lane_q == LAST_LANE));
  assign accept   = in_valid && in_ready;
  assign lane_nxt = lane_q + LW'(1);

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    num_d       = num_q;
    acc_cnt_d   = acc_cnt_q;
    msb_d       = msb_q;
    buf_d       = buf_q;
    full_d      = full_q;
    lane_d      = lane_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    complete_d  = complete_q;

    case (state_q)
      RUN: begin
        if (accept) begin
          buf_d       = in_data;
          full_d      = 1'b1;
          lane_d      = '0;
          acc_cnt_d   = acc_cnt_q + CNT_WIDTH'(1);
          we_d        = 1'b1;
          wdata_d     = in_lane[0];
          addr_d      = next_addr_q;
          next_addr_d = next_addr_q + ADDR_WIDTH'(1);
        end else if (full_q && (lane_q != LAST_LANE)) begin
          lane_d      = lane_nxt;
          we_d        = 1'b1;
          wdata_d     = buf_lane[lane_nxt];
          addr_d      = next_addr_q;
          next_addr_d = next_addr_q + ADDR_WIDTH'(1);
        end else if (full_q) begin
          full_d = 1'b0;
          if (acc_cnt_q == num_q) begin
            state_d    = DONE;
            busy_d     = 1'b0;
            complete_d = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          next_addr_d = base_addr;
          num_d       = num_words;
          msb_d       = msb_first;
          acc_cnt_d   = '0;
          full_d      = 1'b0;
          lane_d      = '0;
          if (num_words == '0) begin
            state_d    = DONE;
            busy_d     = 1'b0;
            complete_d = 1'b1;
          end else begin
            state_d    = RUN;
            busy_d     = 1'b1;
            complete_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      num_q       <= '0;
      acc_cnt_q   <= '0;
      msb_q       <= 1'b0;
      buf_q       <= '0;
      full_q      <= 1'b0;
      lane_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      num_q       <= num_d;
      acc_cnt_q   <= acc_cnt_d;
      msb_q       <= msb_d;
      buf_q       <= buf_d;
      full_q      <= full_d;
      lane_q      <= lane_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      complete_q  <= complete_d;
    end
  end

  assign e_mem_we    = we_q;
  assign e_mem_addr  = addr_q;
  assign e_mem_wdata = wdata_q;
  assign busy        = busy_q;
  assign complete    = complete_q;

endmodule

// File: tb/tb_wb_byte_unpacker.sv
// Scoreboard bench for wb_byte_unpacker: stimulus pushes expected byte writes,
// a negedge monitor pops and compares every write the DUT performs.
module tb_wb_byte_unpacker;

  logic        clk = 1'b0;
  logic        rst_n, start, msb_first, in_valid;
  logic [31:0] base_addr, in_data;
  logic [15:0] num_words;
  logic        in_ready, e_mem_we, busy, complete;
  logic [31:0] e_mem_addr;
  logic [7:0]  e_mem_wdata;

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [39:0] exp_q[$];
  logic [39:0] sb_e;
  int          run_len = 0;
  int          max_run = 0;
  int          acc_cnt = 0;

  wb_byte_unpacker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .msb_first(msb_first), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .e_mem_we(e_mem_we),
    .e_mem_addr(e_mem_addr), .e_mem_wdata(e_mem_wdata), .busy(busy),
    .complete(complete)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (e_mem_we) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%02h expected no write",
                 e_mem_addr, e_mem_wdata);
      end else begin
        sb_e = exp_q.pop_front();
        $display("wr addr=0x%08h data=0x%02h (exp 0x%08h:0x%02h)",
                 e_mem_addr, e_mem_wdata, sb_e[39:8], sb_e[7:0]);
        chk("write_addr_data", {24'd0, e_mem_addr, e_mem_wdata}, {24'd0, sb_e});
      end
    end else begin
      run_len = 0;
    end
    if (in_valid && in_ready) acc_cnt++;
  end

  task automatic push(input logic [31:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n, input logic m);
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    msb_first = m;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Present a word and hold it until the DUT accepts it (bounded).
  task automatic feed(input logic [31:0] w);
    bit acc;
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 100);
    chk("word_accepted", {63'd0, acc}, 64'd1);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!complete && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_complete"}, {63'd0, complete}, 64'd1);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    chk({name, "_sb_empty"}, exp_q.size(), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; msb_first = 1'b0; in_valid = 1'b0;
    base_addr = '0; in_data = '0; num_words = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {e_mem_addr, e_mem_wdata, in_ready, e_mem_we, busy, complete}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single word, LSB first
    do_start(32'h100, 16'd1, 1'b0);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    push(32'h100, 8'hDD); push(32'h101, 8'hCC); push(32'h102, 8'hBB); push(32'h103, 8'hAA);
    feed(32'hAABBCCDD);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("t1_complete_early", {63'd0, complete}, 64'd0);
    @(posedge clk); #1;
    chk("t1_complete_on_time", {63'd0, complete}, 64'd1);
    wait_done("t1");

    // single word, MSB first
    do_start(32'h100, 16'd1, 1'b1);
    chk("t2_complete_cleared", {63'd0, complete}, 64'd0);
    push(32'h100, 8'hAA); push(32'h101, 8'hBB); push(32'h102, 8'hCC); push(32'h103, 8'hDD);
    feed(32'hAABBCCDD);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("t2_complete_on_time", {63'd0, complete}, 64'd1);
    wait_done("t2");

    // back-to-back streaming
    max_run = 0;
    acc_cnt = 0;
    do_start(32'h0, 16'd4, 1'b1);
    for (int i = 0; i < 16; i++) push(i, i[7:0]);
    feed(32'h00010203);
    feed(32'h04050607);
    feed(32'h08090A0B);
    feed(32'h0C0D0E0F);
    in_valid = 1'b0;
    wait_done("t3");
    chk("t3_we_run_len", max_run, 64'd16);
    chk("t3_accept_count", acc_cnt, 64'd4);
    chk("t3_in_ready_low", {63'd0, in_ready}, 64'd0);

    // stalled source, plus a start pulse during RUN that must be ignored
    max_run = 0;
    do_start(32'h40, 16'd2, 1'b0);
    push(32'h40, 8'hEF); push(32'h41, 8'hBE); push(32'h42, 8'hAD); push(32'h43, 8'hDE);
    push(32'h44, 8'h67); push(32'h45, 8'h45); push(32'h46, 8'h23); push(32'h47, 8'h01);
    feed(32'hDEADBEEF);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_start(32'h5000, 16'd7, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_busy_in_gap", {63'd0, busy}, 64'd1);
    feed(32'h01234567);
    in_valid = 1'b0;
    wait_done("t4");
    chk("t4_we_run_len", max_run, 64'd4);

    // zero words
    do_start(32'h80, 16'd0, 1'b0);
    chk("t5_complete_next", {63'd0, complete}, 64'd1);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_complete_held", {63'd0, complete}, 64'd1);

    // address wrap
    do_start(32'hFFFF_FFFE, 16'd1, 1'b1);
    push(32'hFFFF_FFFE, 8'hCA); push(32'hFFFF_FFFF, 8'hFE);
    push(32'h0000_0000, 8'hF0); push(32'h0000_0001, 8'h0D);
    feed(32'hCAFEF00D);
    in_valid = 1'b0;
    wait_done("t6");

    // reset after two bytes
    do_start(32'h200, 16'd1, 1'b0);
    push(32'h200, 8'h44); push(32'h201, 8'h33);
    feed(32'h11223344);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t7_reset_outputs", {e_mem_addr, e_mem_wdata, in_ready, e_mem_we, busy, complete}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_sb_empty", exp_q.size(), 64'd0);
    chk("t7_complete_low", {63'd0, complete}, 64'd0);

    do_start(32'h300, 16'd1, 1'b1);
    push(32'h300, 8'h55); push(32'h301, 8'h66); push(32'h302, 8'h77); push(32'h303, 8'h88);
    feed(32'h55667788);
    in_valid = 1'b0;
    wait_done("t8");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wb_byte_unpacker.md
Name: wb_byte_unpacker

Overview:
- Write-back engine: the reverse of the byte-to-word load path.
- Accepts wide words from the BRAM read side and serialises each into bytes.
- Writes the bytes to external memory at consecutive byte addresses, one byte per cycle at full throughput.
- Sits between the 32-bit BRAM read port and the 8-bit external memory write interface; signals completion to the control module.

Parameters:
- DATA_WIDTH_W, 32, input word width (must be an integer multiple of DATA_WIDTH_R).
- DATA_WIDTH_R, 8, external memory byte width.
- ADDR_WIDTH, 32, external memory address width.
- CNT_WIDTH, 16, width of the word-count field.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that launches a transfer.
- base_addr  in  ADDR_WIDTH  first external byte address; sampled at start.
- num_words  in  CNT_WIDTH  words to write back; sampled at start.
- msb_first  in  1  lane order (1: bits [31:24] written first; 0: bits [7:0] first); sampled at start.
- in_valid  in  1  word source has valid data.
- in_data  in  DATA_WIDTH_W  word from BRAM read path.
- in_ready  out  1  block accepts a word this cycle.
- e_mem_we  out  1  external byte write strobe.
- e_mem_addr  out  ADDR_WIDTH  external byte address.
- e_mem_wdata  out  DATA_WIDTH_R  external byte data.
- busy  out  1  transfer in progress.
- complete  out  1  transfer finished; level, held until next start or reset.

Behaviour:
- Definitions:
  - N = DATA_WIDTH_W/DATA_WIDTH_R (4 at defaults).
  - Word accepted on a rising edge where in_valid && in_ready.
- States: IDLE, RUN, DONE. Reset (rst_n=0 at an edge) forces IDLE.
  - Reset values: in_ready=0, e_mem_we=0, e_mem_addr=0, e_mem_wdata=0, busy=0, complete=0.
  - Any buffered word and all counters are discarded.
- IDLE/DONE, start=1:
  - Latch base_addr, num_words, msb_first.
  - Clear counters and complete.
  - Go to RUN, except num_words==0: go to DONE with complete=1 next cycle and no writes.
- start while in RUN is ignored.
- RUN:
  - busy=1.
  - Internal one-word buffer plus lane index 0..N-1.
  - in_ready=1 when fewer than num_words words have been accepted AND (buffer empty OR lane index==N-1 this cycle).
    - This gives gapless back-to-back streaming.
  - Latency: word accepted at edge t → its first byte is driven in the cycle after edge t; e_mem_we=1 for N consecutive cycles.
  - e_mem_wdata:
    - msb_first=1: lane k = bits [W-1-8k -: 8].
    - msb_first=0: lane k = bits [8k +: 8].
  - e_mem_addr = latched base + running byte count, modulo 2^ADDR_WIDTH (wraps 0xFFFFFFFF→0x00000000 silently).
  - Buffer empty and no word accepted → e_mem_we=0; address and byte count hold.
  - e_mem_we, e_mem_addr and e_mem_wdata are driven from registers only; no combinational path from in_valid or in_data.
  - in_data is ignored when not accepted.
- Completion:
  - On the edge that writes byte num_words*N-1, go to DONE.
  - In DONE: complete=1, busy=0, in_ready=0, e_mem_we=0.
- Reset during RUN aborts immediately: no further writes, and partial data is not flushed.

Test Plan:
- Single word, LSB first: start with base_addr=0x100, num_words=1, msb_first=0; in_data=0xAABBCCDD accepted → 4 consecutive cycles writing 0x100:DD, 0x101:CC, 0x102:BB, 0x103:AA. Next cycle complete=1, busy=0.
- Single word, MSB first: same stimulus with msb_first=1 → 0x100:AA, 0x101:BB, 0x102:CC, 0x103:DD.
- Back-to-back: num_words=4, in_valid held high with 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, msb_first=1, base=0 → e_mem_we high 16 consecutive cycles, addresses 0..15, data 0x00..0x0F. in_ready high exactly 4 accept cycles, then low.
- Stalled source: num_words=2, second word presented 5 cycles late → gap in e_mem_we; second word's bytes at base+4..base+7 with no skipped addresses.
- Zero words and ignored start: num_words=0 → complete=1 one cycle after start, e_mem_we never asserted. Separately, a start pulse during RUN does not change addresses or counts.
- Address wrap and mid-transfer reset:
  - base=0xFFFFFFFE, num_words=1 → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
  - rst_n=0 after 2 bytes → all outputs 0 at next edge, no further writes; a fresh start then completes normally.
